// File: rtl/tx_pkg.sv
// -----------------------------------------------------------------------------
// tx_pkg
// Shared definitions for the TX arbiter slice:
//   - LENGTH_DEF / DEPTH_DEF : default threshold/fill width and FIFO depth
//   - state_e                : arbiter FSM state encoding (visible on state_out)
//   - is_hold_state()        : states in which back-pressure is forced high
// -----------------------------------------------------------------------------
package tx_pkg;

    localparam int unsigned LENGTH_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 8;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    // RESET, INIT and ERROR pin Main_pause high regardless of occupancy.
    function automatic logic is_hold_state(input state_e st);
        logic hold;
        case (st)
            ST_RESET: hold = 1'b1;
            ST_INIT:  hold = 1'b1;
            ST_ERROR: hold = 1'b1;
            default:  hold = 1'b0;
        endcase
        return hold;
    endfunction

endpackage

// File: rtl/tx_arb_grant.sv
// -----------------------------------------------------------------------------
// tx_arb_grant
// Picks at most one virtual channel out of the eligible set.
//   clk_i   : clock (rising edge), only used by the round-robin pointer
//   rst_n_i : asynchronous active-low reset
//   elig_i  : [0]=VC0 eligible, [1]=VC1 eligible (already destination-checked)
//   grant_o : one-hot grant, 2'b00 when nothing is eligible
// Build option: TX_ARB_ROUND_ROBIN_EN selects alternating priority; otherwise
// VC0 always wins over VC1.
// -----------------------------------------------------------------------------
module tx_arb_grant
    import tx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] elig_i,
    output logic [1:0] grant_o
);

`ifdef TX_ARB_ROUND_ROBIN_EN
    // last_q = 1 means VC1 was granted last, so VC0 has priority next.
    logic last_q;
    logic last_d;

    // Grant selection: when both are eligible, favour the one not served last.
    always_comb begin
        grant_o = 2'b00;
        last_d  = last_q;
        if (elig_i == 2'b11) begin
            if (last_q) begin
                grant_o = 2'b01;
            end else begin
                grant_o = 2'b10;
            end
        end else begin
            grant_o = elig_i;
        end
        if (grant_o != 2'b00) begin
            last_d = grant_o[1];
        end else begin
            last_d = last_q;
        end
    end

    // Round-robin pointer register, reset so that VC0 wins the first contest.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_s;
    assign unused_s = clk_i ^ rst_n_i;

    // Fixed priority: VC0 first, VC1 only when VC0 cannot go.
    always_comb begin
        grant_o = 2'b00;
        if (elig_i[0]) begin
            grant_o = 2'b01;
        end else if (elig_i[1]) begin
            grant_o = 2'b10;
        end else begin
            grant_o = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
// Moves words from two virtual-channel FIFOs (VC0/VC1) to two destination
// FIFOs (D0/D1), one pop per cycle, with almost-full back-pressure toward the
// source and main-FIFO overflow detection.
//
// Ports
//   clk, reset (async, active-low), init (load thresholds)
//   push, MF_full               : main FIFO write request / full flag
//   Umbral_MF_in/_VC_in/_D_in   : almost-full thresholds (LENGTH bits)
//   MF_fill, VC0/VC1/D0/D1_fill : FIFO occupancies (LENGTH bits)
//   VC0_dest, VC1_dest          : destination bit of each VC head word
//   pop_VC0, pop_VC1            : registered VC read strobes (never both high)
//   push_D0, push_D1            : registered destination write strobes
//   Main_pause                  : registered back-pressure to the source
//   idle, error_out, state_out  : status
//
// Build option: TX_ARB_ROUND_ROBIN_EN (round-robin VC priority in tx_arb_grant).
// -----------------------------------------------------------------------------
module tx_arbiter
    import tx_pkg::*;
#(
    parameter int unsigned LENGTH = LENGTH_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              push,
    input  logic              MF_full,
    input  logic [LENGTH-1:0] Umbral_MF_in,
    input  logic [LENGTH-1:0] Umbral_VC_in,
    input  logic [LENGTH-1:0] Umbral_D_in,
    input  logic [LENGTH-1:0] MF_fill,
    input  logic [LENGTH-1:0] VC0_fill,
    input  logic [LENGTH-1:0] VC1_fill,
    input  logic [LENGTH-1:0] D0_fill,
    input  logic [LENGTH-1:0] D1_fill,
    input  logic              VC0_dest,
    input  logic              VC1_dest,
    output logic              pop_VC0,
    output logic              pop_VC1,
    output logic              push_D0,
    output logic              push_D1,
    output logic              Main_pause,
    output logic              idle,
    output logic              error_out,
    output logic [2:0]        state_out
);

    localparam logic [LENGTH:0] DEPTH_W = (LENGTH + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [LENGTH-1:0] u_mf_q, u_vc_q, u_d_q;
    logic [LENGTH-1:0] u_mf_d, u_vc_d, u_d_d;
    logic [1:0]        infl0_q, infl1_q, infl0_d, infl1_d;
    logic              pop0_q, pop1_q, pop0_d, pop1_d;
    logic              push0_q, push1_q, push0_d, push1_d;
    logic              dest_q, dest_d;
    logic              pause_q, pause_d;

    logic              overflow_s;
    logic              any_fill_s;
    logic              busy_s;
    logic              can_pop_s;
    logic              vc0_avail_s, vc1_avail_s;
    logic              d0_room_s, d1_room_s;
    logic              vc0_dest_ok_s, vc1_dest_ok_s;
    logic [1:0]        elig_s;
    logic [1:0]        grant_s;
    logic              inc0_s, inc1_s;

    // Overflow: a write into a main FIFO that is full (flag or fill at depth).
    always_comb begin
        overflow_s = push && (MF_full || ({1'b0, MF_fill} >= DEPTH_W));
        any_fill_s = (|MF_fill) || (|VC0_fill) || (|VC1_fill) || (|D0_fill) || (|D1_fill);
        busy_s     = (infl0_q != 2'd0) || (infl1_q != 2'd0) ||
                     pop0_q || pop1_q || push0_q || push1_q;
    end

    // FSM next-state: init has priority, ERROR is sticky until init.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
            end
            ST_INIT: begin
                if (init) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if (overflow_s) begin
                    state_d = ST_ERROR;
                end else if (any_fill_s) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if (overflow_s) begin
                    state_d = ST_ERROR;
                end else if (!any_fill_s && !busy_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                if (init) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Eligibility: pops only while staying in ACTIVE, a VC needs more words
    // than it popped last cycle, and its destination needs room after counting
    // words already popped toward it (sum is LENGTH+1 bits so it cannot wrap).
    always_comb begin
        can_pop_s     = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE);
        vc0_avail_s   = VC0_fill > {{(LENGTH-1){1'b0}}, pop0_q};
        vc1_avail_s   = VC1_fill > {{(LENGTH-1){1'b0}}, pop1_q};
        d0_room_s     = ({1'b0, D0_fill} + {{(LENGTH-1){1'b0}}, infl0_q}) < {1'b0, u_d_q};
        d1_room_s     = ({1'b0, D1_fill} + {{(LENGTH-1){1'b0}}, infl1_q}) < {1'b0, u_d_q};
        if (VC0_dest) begin
            vc0_dest_ok_s = d1_room_s;
        end else begin
            vc0_dest_ok_s = d0_room_s;
        end
        if (VC1_dest) begin
            vc1_dest_ok_s = d1_room_s;
        end else begin
            vc1_dest_ok_s = d0_room_s;
        end
        elig_s = {can_pop_s && vc1_avail_s && vc1_dest_ok_s,
                  can_pop_s && vc0_avail_s && vc0_dest_ok_s};
    end

    tx_arb_grant u_grant (
        .clk_i   (clk),
        .rst_n_i (reset),
        .elig_i  (elig_s),
        .grant_o (grant_s)
    );

    // Datapath next values: pops, latched destination, one-cycle-late pushes,
    // in-flight counters, thresholds and back-pressure.
    always_comb begin
        pop0_d = grant_s[0];
        pop1_d = grant_s[1];
        if (grant_s[1]) begin
            dest_d = VC1_dest;
        end else begin
            dest_d = VC0_dest;
        end
        push0_d = (pop0_q || pop1_q) && !dest_q;
        push1_d = (pop0_q || pop1_q) && dest_q;

        // A pop adds to its destination's count; the push that completes it
        // removes it, so each counter stays within 0..2.
        inc0_s  = (pop0_d || pop1_d) && !dest_d;
        inc1_s  = (pop0_d || pop1_d) && dest_d;
        infl0_d = infl0_q + {1'b0, inc0_s} - {1'b0, push0_q};
        infl1_d = infl1_q + {1'b0, inc1_s} - {1'b0, push1_q};

        if (init) begin
            u_mf_d = Umbral_MF_in;
            u_vc_d = Umbral_VC_in;
            u_d_d  = Umbral_D_in;
        end else begin
            u_mf_d = u_mf_q;
            u_vc_d = u_vc_q;
            u_d_d  = u_d_q;
        end

        if (is_hold_state(state_d)) begin
            pause_d = 1'b1;
        end else begin
            pause_d = (MF_fill >= u_mf_q) || (VC0_fill >= u_vc_q) || (VC1_fill >= u_vc_q);
        end
    end

    // State, thresholds, counters and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            u_mf_q  <= '0;
            u_vc_q  <= '0;
            u_d_q   <= '0;
            infl0_q <= 2'd0;
            infl1_q <= 2'd0;
            pop0_q  <= 1'b0;
            pop1_q  <= 1'b0;
            push0_q <= 1'b0;
            push1_q <= 1'b0;
            dest_q  <= 1'b0;
            pause_q <= 1'b1;
        end else begin
            state_q <= state_d;
            u_mf_q  <= u_mf_d;
            u_vc_q  <= u_vc_d;
            u_d_q   <= u_d_d;
            infl0_q <= infl0_d;
            infl1_q <= infl1_d;
            pop0_q  <= pop0_d;
            pop1_q  <= pop1_d;
            push0_q <= push0_d;
            push1_q <= push1_d;
            dest_q  <= dest_d;
            pause_q <= pause_d;
        end
    end

    assign pop_VC0    = pop0_q;
    assign pop_VC1    = pop1_q;
    assign push_D0    = push0_q;
    assign push_D1    = push1_q;
    assign Main_pause = pause_q;
    assign idle       = (state_q == ST_IDLE);
    assign error_out  = (state_q == ST_ERROR);
    assign state_out  = state_q;

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameters SHALL be LENGTH (default 8, width of thresholds and fill counts) and DEPTH (default 8, FIFO depth used for error checks).
REQ-002 Ports SHALL be: clk, reset, init, push, MF_full, Umbral_MF_in/Umbral_VC_in/Umbral_D_in, MF_fill/VC0_fill/VC1_fill/D0_fill/D1_fill, VC0_dest/VC1_dest, pop_VC0/pop_VC1, push_D0/push_D1, Main_pause, idle, error_out, state_out.
REQ-003 clk: input, 1 bit, sole clock; all logic on the rising edge.
REQ-004 reset: input, 1 bit, asynchronous, active-low.
REQ-005 init: input, 1 bit, high SHALL load new thresholds.
REQ-006 push / MF_full: inputs, 1 bit each, main-FIFO write request and full flag, used for overflow detection.
REQ-007 Umbral_MF_in, Umbral_VC_in, Umbral_D_in: inputs, LENGTH bits each, almost-full thresholds.
REQ-008 MF_fill, VC0_fill, VC1_fill, D0_fill, D1_fill: inputs, LENGTH bits each, current FIFO occupancy.
REQ-009 VC0_dest, VC1_dest: inputs, 1 bit each, bit 4 of the head word of each VC FIFO (0 -> D0, 1 -> D1).
REQ-010 pop_VC0, pop_VC1: outputs, 1 bit each, registered VC FIFO read strobes; never both high.
REQ-011 push_D0, push_D1: outputs, 1 bit each, registered destination write strobes.
REQ-012 Main_pause: output, 1 bit, registered back-pressure to the source.
REQ-013 idle, error_out: outputs, 1 bit each; state_out: output, 3 bits, current FSM state encoding.

Function
REQ-014 FSM states SHALL be RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-015 RESET SHALL advance to INIT on the first clock after reset deasserts.
REQ-016 INIT SHALL capture all three thresholds every cycle init is high, and SHALL go to IDLE on the first cycle init is low.
REQ-017 From IDLE, ACTIVE or ERROR, init=1 SHALL move to INIT; ERROR is otherwise sticky.
REQ-018 IDLE SHALL go to ACTIVE when any fill input is nonzero; ACTIVE SHALL go to IDLE when all fills are zero and nothing is in flight.
REQ-019 push=1 with MF_full=1 in IDLE or ACTIVE SHALL move to ERROR next cycle; ERROR SHALL force error_out=1, Main_pause=1 and no new pops.
REQ-020 Main_pause SHALL be registered (MF_fill>=U_MF) or (VC0_fill>=U_VC) or (VC1_fill>=U_VC); it SHALL be held at 1 in RESET, INIT and ERROR.
REQ-021 VCx SHALL be eligible only in ACTIVE when VCx_fill exceeds the VCx pops issued last cycle (0 or 1).
REQ-022 Destination Dy SHALL accept only while Dy_fill + inflight_y < U_D; inflight_y (0..2) counts pops to Dy not yet written.
REQ-023 A pop issued at cycle N SHALL latch its dest and assert the matching push_Dy at N+1 (latency 1).
REQ-024 If the chosen VC's destination is blocked, that VC SHALL be skipped, and the other VC MAY be popped in the same cycle.
REQ-025 All comparisons SHALL be unsigned LENGTH-bit; the U_D sum SHALL use LENGTH+1 bits so it cannot wrap.
REQ-026 idle SHALL be 1 exactly when state=IDLE.

Reset
REQ-027 While reset=0: state=RESET; thresholds=0; inflight=0; pop/push outputs=0; Main_pause=1; idle=0; error_out=0.
REQ-028 Reset asserted mid-transfer SHALL drop a pending push_Dy immediately, with no completion after release.

Configuration
REQ-029 With TX_ARB_ROUND_ROBIN_EN defined, a 1-bit last-grant register SHALL alternate priority between eligible VCs, reset value VC1 so VC0 wins first.
REQ-030 Without TX_ARB_ROUND_ROBIN_EN, VC0 SHALL have fixed priority over VC1.

Structure
REQ-031 State encodings and the LENGTH/DEPTH defaults SHALL live in shared package tx_pkg.
REQ-032 Grant selection (eligibility in, one-hot grant out, optional round-robin pointer) SHALL be sub-module tx_arb_grant; FSM, counters and output registers stay in tx_arbiter.

Verification
REQ-033 Reset released, init=1 for 1 cycle with U_D=1, U_MF=1, U_VC=3, then init=0 -> INIT for 1 cycle, then IDLE; idle=1; Main_pause=0.
REQ-034 VC0_fill=2, VC0_dest=0, D0_fill=0, U_D=2 -> pop_VC0 at N, push_D0 at N+1; at most 2 writes to D0 before D0_fill rises.
REQ-035 VC0_fill=3, VC1_fill=3, all dest=1, U_D=8 -> fixed build: VC1 never popped; round-robin build: grants alternate VC0, VC1, VC0.
REQ-036 MF_fill=1 with U_MF=1 -> Main_pause=1 next cycle; MF_fill=0 -> Main_pause=0 next cycle.
REQ-037 push=1, MF_full=1 in ACTIVE -> state 4, error_out=1, pops stop; then init=1 -> state 1, error_out=0.
REQ-038 reset=0 asserted the cycle after pop_VC1 -> push_D1 never asserts and all outputs take reset values.
